fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Read-side consumer of the async FIFO in the TX clock domain.
- Drains bytes from the FIFO read port (RD_DATA / EMPTY / R_INC) and serialises each as a UART frame: start, data LSB-first, optional parity, stop. One bit per CLK cycle; CLK is the already-divided TX bit clock.
- Sits between the FIFO and the UART TX pad; BUSY feeds the pulse generator and system controller.

Parameters:
- DATA_WIDTH, 8, FIFO word / frame data width; must match the FIFO DATA_WIDTH.

Ports:
- CLK  input  1  TX bit clock; same clock as FIFO R_CLK.
- RST  input  1  synchronous, active-high reset.
- FIFO_RD_DATA  input  DATA_WIDTH  FIFO RD_DATA; valid combinationally whenever FIFO_EMPTY=0.
- FIFO_EMPTY  input  1  FIFO EMPTY flag.
- FIFO_RD_INC  output  1  to FIFO R_INC; one-cycle pop pulse.
- TX_EN  input  1  permits starting new frames.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  serial line, registered, idles high.
- BUSY  output  1  registered, high while a frame is on the line.

Behaviour:
- Clock and reset: one clock (CLK). RST is synchronous and active-high. The reset port is named RST.
- Reset values: state=IDLE, TX_OUT=1, BUSY=0, FIFO_RD_INC=0, shift register=0, bit counter=0.
- States: IDLE, START, DATA, PARITY, STOP. TX_OUT and BUSY are registered from the next-state decode, so each state's line value appears in the cycle that state is occupied.
- Load condition: load = TX_EN & ~FIFO_EMPTY & (state==IDLE | state==STOP).
- FIFO_RD_INC is combinational and equals load. It is asserted for exactly one cycle per frame. On that same edge:
  - FIFO_RD_DATA is captured into the shift register.
  - PAR_EN and PAR_TYP are latched for the frame.
  - Parity is computed from the captured byte.
- IDLE: TX_OUT=1, BUSY=0. On load → START.
- START: TX_OUT=0, BUSY=1, one cycle → DATA, bit counter=0.
- DATA: TX_OUT = data bit [counter], LSB first, for DATA_WIDTH cycles. After the last bit → PARITY if the latched PAR_EN=1, else → STOP.
- PARITY: TX_OUT = ^data XOR latched PAR_TYP, one cycle → STOP.
- STOP: TX_OUT=1, BUSY=1, one cycle. Then:
  - load → START (back-to-back, no idle gap).
  - otherwise → IDLE.
- Frame length: 10 cycles, or 11 with parity. Latency from the load cycle to the start bit on TX_OUT is 1 cycle.
- Mid-frame changes: TX_EN, PAR_EN and PAR_TYP changes mid-frame do not affect the current frame. TX_EN=0 only blocks the next load.
- FIFO_EMPTY is ignored outside IDLE and STOP. The next load opportunity is at least 10 cycles after a pop, so the flag has settled by then.
- RST mid-frame: next edge goes to IDLE with TX_OUT=1 and BUSY=0. The popped byte is discarded; no FIFO_RD_INC is asserted in the reset cycle.
- Empty FIFO: no pulse, line stays high indefinitely.

Optional Feature:
- Macro: FIFO_UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles (stop-bit counter). Load and back-to-back transfer are evaluated only in the second stop cycle. Frame length becomes 11, or 12 with parity.
- Undefined: single stop bit as above; no extra logic.

Decomposition:
- Shared package fifo_uart_tx_pkg:
  - state encoding localparams: IDLE, START, DATA, PARITY, STOP.
  - PAR_EVEN=0, PAR_ODD=1.
  - frame-length constants.
- One natural sub-module: tx_parity_calc. It is combinational: data + PAR_TYP → parity bit, and is reused by the UART RX checker.

Test Plan:
- Reset: assert RST 3 cycles with FIFO_EMPTY=0 → TX_OUT=1, BUSY=0, FIFO_RD_INC=0 throughout, no pop.
- Single byte 0xA5, PAR_EN=0 → one FIFO_RD_INC pulse; next cycles TX_OUT = 0,1,0,1,0,0,1,0,1,1; BUSY high exactly 10 cycles.
- 0xA5 with PAR_EN=1 → parity bit 0 with PAR_TYP=0 and 1 with PAR_TYP=1. 0x01 even → parity 1. 11-cycle frames.
- FIFO holding 0x55 then 0xAA, TX_EN=1:
  - second FIFO_RD_INC occurs in the STOP cycle of frame 1.
  - start bit of frame 2 follows the stop bit immediately; BUSY never drops.
  - total 20 cycles.
- TX_EN=0 with a non-empty FIFO → no pop, line idle. Dropping TX_EN mid-frame → current frame completes, no further pop.
- RST at the 4th data bit → next cycle TX_OUT=1, BUSY=0. After release with a non-empty FIFO, a new frame starts with the next FIFO word.
- With FIFO_UART_TX_TWO_STOP_EN → frame 0x00 ends with 2 high cycles; BUSY high 11 cycles.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// FIFO_UART_TX_TWO_STOP_EN selects two stop bits instead of one.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

`ifdef FIFO_UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  // Line cycles per frame: start + data + optional parity + stop(s).
  function automatic int frame_len(input int data_width, input logic par_en);
    return 1 + data_width + (par_en ? 1 : 0) + STOP_BITS;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port, frame controls and serial line of the UART transmitter.
// The transmitter uses the slave view; the FIFO/controller side uses master.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] FIFO_RD_DATA;
  logic                  FIFO_EMPTY;
  logic                  FIFO_RD_INC;
  logic                  TX_EN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output FIFO_RD_DATA, FIFO_EMPTY, TX_EN, PAR_EN, PAR_TYP,
    input  FIFO_RD_INC, TX_OUT, BUSY
  );

  modport slave (
    input  FIFO_RD_DATA, FIFO_EMPTY, TX_EN, PAR_EN, PAR_TYP,
    output FIFO_RD_INC, TX_OUT, BUSY
  );

endinterface

// File: rtl/fifo_uart_tx_parity_calc.sv
// Combinational UART parity: even (par_typ=0) or odd (par_typ=1) over data.
// Shared with the UART RX checker.
module tx_parity_calc
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the async FIFO read port and serialises each word as a UART frame,
// one bit per CLK. Define FIFO_UART_TX_TWO_STOP_EN for two stop bits.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  fifo_uart_tx_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d, par_bit_w;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  stop_last;
  logic                  load;

`ifdef FIFO_UART_TX_TWO_STOP_EN
  logic stop_cnt_q, stop_cnt_d;
  assign stop_last = stop_cnt_q;
`else
  assign stop_last = 1'b1;
`endif

  // Reset gates the pop so an aborted frame never consumes a second word.
  assign load = ~RST & bus.TX_EN & ~bus.FIFO_EMPTY &
                ((state_q == IDLE) | ((state_q == STOP) & stop_last));

  assign bus.FIFO_RD_INC = load;
  assign bus.TX_OUT      = tx_out_q;
  assign bus.BUSY        = busy_q;

  tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (bus.FIFO_RD_DATA),
    .par_typ (bus.PAR_TYP),
    .par_bit (par_bit_w)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`ifdef FIFO_UART_TX_TWO_STOP_EN
    stop_cnt_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (load) state_d = START;
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          shift_d   = shift_q >> 1;
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
`ifdef FIFO_UART_TX_TWO_STOP_EN
        if (!stop_cnt_q) stop_cnt_d = 1'b1;
        else             state_d = load ? START : IDLE;
`else
        state_d = load ? START : IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Frame settings are frozen at the pop so later input changes wait a frame.
    if (load) begin
      shift_d   = bus.FIFO_RD_DATA;
      par_en_d  = bus.PAR_EN;
      par_bit_d = par_bit_w;
    end
  end

  // Line and busy are decoded from the next state so they register in step.
  always_comb begin
    tx_out_d = 1'b1;
    busy_d   = 1'b1;
    case (state_d)
      IDLE:    busy_d   = 1'b0;
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = par_bit_q;
      default: tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
`ifdef FIFO_UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: stimulus queues expected line bits and
// busy-run lengths, a negedge monitor pops and compares them.
module tb_fifo_uart_tx;

  localparam int DW = 8;
`ifdef FIFO_UART_TX_TWO_STOP_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mon_en = 1'b0;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  fifo_uart_tx #(.DATA_WIDTH(DW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: written by stimulus, popped on FIFO_RD_INC.
  logic [DW-1:0] mem [16];
  logic [3:0]    wr_ptr = 4'd0;
  logic [3:0]    rd_ptr = 4'd0;

  assign bus.FIFO_RD_DATA = mem[rd_ptr];
  assign bus.FIFO_EMPTY   = (wr_ptr == rd_ptr);

  always @(posedge clk) if (bus.FIFO_RD_INC) rd_ptr <= rd_ptr + 4'd1;

  bit exp_q[$];
  int len_q[$];
  int checks = 0;
  int errors = 0;
  int exp_pops = 0;
  int run = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_fifo(input logic [DW-1:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
    exp_pops++;
  endtask

  // Expected line bits of a frame; nbits<0 queues the whole frame.
  task automatic expect_frame(input logic [DW-1:0] b, input logic pen,
                              input logic ptyp, input int nbits, output int pushed);
    bit frame[$];
    int ones = 0;
    frame.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      frame.push_back(b[i]);
      if (b[i]) ones++;
    end
    if (pen) frame.push_back(ptyp ? (ones % 2 == 0) : (ones % 2 == 1));
    for (int i = 0; i < N_STOP; i++) frame.push_back(1'b1);
    pushed = 0;
    foreach (frame[i]) begin
      if (nbits < 0 || i < nbits) begin
        exp_q.push_back(frame[i]);
        pushed++;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && len_q.size() == 0) break;
    end
    if (i == budget) begin
      errors++;
      $display("FAIL wait_idle: timeout with %0d bits %0d runs pending", exp_q.size(), len_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) chk("rd_inc_in_reset", int'(bus.FIFO_RD_INC), 0);
      if (bus.BUSY) begin
        run++;
        if (exp_q.size() == 0) chk("unexpected_busy_bit", int'(bus.TX_OUT), -1);
        else chk("tx_bit", int'(bus.TX_OUT), int'(exp_q.pop_front()));
      end else begin
        chk("idle_line", int'(bus.TX_OUT), 1);
        if (run != 0) begin
          if (len_q.size() == 0) chk("unexpected_busy_run", run, 0);
          else chk("busy_len", run, len_q.pop_front());
          run = 0;
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    rst         = 1'b1;
    bus.TX_EN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held with a non-empty FIFO, then single 0xA5 frame without parity.
    push_fifo(8'hA5);
    expect_frame(8'hA5, 1'b0, 1'b0, -1, n);
    len_q.push_back(n);
    repeat (2) @(posedge clk);
    #1;
    chk("no_pop_in_reset", int'(rd_ptr), 0);
    rst = 1'b0;
    wait_idle(40);
    chk("pop_count_a5", int'(rd_ptr), exp_pops);

    // Parity frames: 0xA5 even, 0xA5 odd, 0x01 even.
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = 1'b0;
    push_fifo(8'hA5);
    expect_frame(8'hA5, 1'b1, 1'b0, -1, n);
    len_q.push_back(n);
    wait_idle(40);
    bus.PAR_TYP = 1'b1;
    push_fifo(8'hA5);
    expect_frame(8'hA5, 1'b1, 1'b1, -1, n);
    len_q.push_back(n);
    wait_idle(40);
    bus.PAR_TYP = 1'b0;
    push_fifo(8'h01);
    expect_frame(8'h01, 1'b1, 1'b0, -1, n);
    len_q.push_back(n);
    wait_idle(40);

    // Parity settings changed mid-frame must not touch the current frame.
    bus.PAR_TYP = 1'b1;
    push_fifo(8'h6B);
    expect_frame(8'h6B, 1'b1, 1'b1, -1, n);
    len_q.push_back(n);
    repeat (3) @(posedge clk);
    #1;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    wait_idle(40);

    // Back-to-back 0x55 then 0xAA: one continuous busy run.
    push_fifo(8'h55);
    push_fifo(8'hAA);
    expect_frame(8'h55, 1'b0, 1'b0, -1, n);
    expect_frame(8'hAA, 1'b0, 1'b0, -1, n2);
    len_q.push_back(n + n2);
    wait_idle(60);
    chk("pop_count_b2b", int'(rd_ptr), exp_pops);

    // TX_EN low blocks the pop; raising it releases the frame.
    bus.TX_EN = 1'b0;
    push_fifo(8'h3C);
    expect_frame(8'h3C, 1'b0, 1'b0, -1, n);
    len_q.push_back(n);
    repeat (15) @(posedge clk);
    #1;
    chk("no_pop_tx_en_low", int'(rd_ptr), exp_pops - 1);
    bus.TX_EN = 1'b1;
    wait_idle(40);

    // TX_EN dropped mid-frame: frame completes, second word stays queued.
    push_fifo(8'h0F);
    push_fifo(8'hF0);
    expect_frame(8'h0F, 1'b0, 1'b0, -1, n);
    len_q.push_back(n);
    repeat (2) @(posedge clk);
    #1;
    bus.TX_EN = 1'b0;
    wait_idle(40);
    repeat (12) @(posedge clk);
    #1;
    chk("no_pop_after_drop", int'(rd_ptr), exp_pops - 1);

    // Reset during the 4th data bit of 0xF0, then 0xC3 follows.
    push_fifo(8'hC3);
    expect_frame(8'hF0, 1'b0, 1'b0, 5, n);
    len_q.push_back(n);
    expect_frame(8'hC3, 1'b0, 1'b0, -1, n);
    len_q.push_back(n);
    bus.TX_EN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle(40);
    chk("pop_count_reset", int'(rd_ptr), exp_pops);

    // All-zero word: only the stop bit(s) are high.
    push_fifo(8'h00);
    expect_frame(8'h00, 1'b0, 1'b0, -1, n);
    len_q.push_back(n);
    wait_idle(40);

    repeat (3) @(posedge clk);
    #1;
    chk("bits_left", exp_q.size(), 0);
    chk("fifo_drained", int'(rd_ptr), int'(wr_ptr));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
